// File: rtl/normalizer_pipe.sv
// normalizer_pipe: two-stage valid/ready normaliser for the FP adder datapath.
// Stage 1 classifies the raw sum (zero / right shift / left shift) and counts
// leading zeros. Stage 2 applies the shift, adjusts the exponent and raises
// the zero/overflow/underflow flags.
// Optional build macro NORM_STATS_EN adds saturating overflow/underflow
// completion counters with a synchronous clear.
module normalizer_pipe #(
  parameter int EXP_WIDTH      = 8,
  parameter int MANTISSA_WIDTH = 23,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      valid_in,
  output logic                      ready_in,
  input  logic [EXP_WIDTH-1:0]      expoent_in,
  input  logic [MANTISSA_WIDTH+1:0] result_in,
  output logic                      valid_out,
  input  logic                      ready_out,
  output logic [EXP_WIDTH-1:0]      normal_e_out,
  output logic [MANTISSA_WIDTH:0]   normal_m_out,
  output logic                      zero_out,
  output logic                      overflow_out,
`ifdef NORM_STATS_EN
  input  logic                      clr_stats_in,
  output logic [CNT_WIDTH-1:0]      ovf_count_out,
  output logic [CNT_WIDTH-1:0]      unf_count_out,
`endif
  output logic                      underflow_out
);

  localparam int MW = MANTISSA_WIDTH;
  localparam int EW = EXP_WIDTH;
  localparam int SW = (MW > 0) ? $clog2(MW + 1) : 1;
  localparam int CW = (EW > SW) ? EW : SW;

  typedef enum logic [1:0] {
    CLS_ZERO  = 2'd0,
    CLS_RIGHT = 2'd1,
    CLS_LEFT  = 2'd2
  } cls_e;

  logic          s1_valid_q;
  logic [EW-1:0] s1_exp_q;
  logic [MW+1:0] s1_res_q;
  cls_e          s1_cls_q, s1_cls_d;
  logic [SW-1:0] s1_lz_q, s1_lz_d;

  logic          s2_valid_q;
  logic [EW-1:0] s2_e_q, s2_e_d;
  logic [MW:0]   s2_m_q, s2_m_d;
  logic          s2_zero_q, s2_zero_d;
  logic          s2_ovf_q, s2_ovf_d;
  logic          s2_unf_q, s2_unf_d;

  logic          s2_load;
  logic          s1_load;
  logic [EW:0]   e_inc;
  logic [CW-1:0] exp_ext;
  logic [CW-1:0] lz_ext;

  assign s2_load  = !s2_valid_q || ready_out;
  assign s1_load  = !s1_valid_q || s2_load;
  assign ready_in = s1_load;

  // Stage 1 classification; the highest set bit of result_in[MW:0] sets the count
  always_comb begin
    s1_lz_d = SW'(MW);
    for (int i = 0; i <= MW; i++) begin
      if (result_in[i]) s1_lz_d = SW'(MW - i);
    end
    if (result_in == '0)      s1_cls_d = CLS_ZERO;
    else if (result_in[MW+1]) s1_cls_d = CLS_RIGHT;
    else                      s1_cls_d = CLS_LEFT;
  end

  // Stage 1 registers: hold operand while stage 2 is blocked
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_valid_q <= 1'b0;
      s1_exp_q   <= '0;
      s1_res_q   <= '0;
      s1_cls_q   <= CLS_ZERO;
      s1_lz_q    <= '0;
    end else if (s1_load) begin
      s1_valid_q <= valid_in;
      if (valid_in) begin
        s1_exp_q <= expoent_in;
        s1_res_q <= result_in;
        s1_cls_q <= s1_cls_d;
        s1_lz_q  <= s1_lz_d;
      end
    end
  end

  assign e_inc   = {1'b0, s1_exp_q} + {{EW{1'b0}}, 1'b1};
  assign exp_ext = CW'(s1_exp_q);
  assign lz_ext  = CW'(s1_lz_q);

  // Stage 2 normalisation; exponent 0 is reserved, so exp <= shift underflows
  always_comb begin
    s2_e_d    = '0;
    s2_m_d    = '0;
    s2_zero_d = 1'b0;
    s2_ovf_d  = 1'b0;
    s2_unf_d  = 1'b0;
    case (s1_cls_q)
      CLS_ZERO: s2_zero_d = 1'b1;
      CLS_RIGHT: begin
        if (e_inc >= {1'b0, {EW{1'b1}}}) begin
          s2_ovf_d = 1'b1;
          s2_e_d   = '1;
        end else begin
          s2_e_d = e_inc[EW-1:0];
          s2_m_d = s1_res_q[MW+1:1];
        end
      end
      default: begin
        if (exp_ext <= lz_ext) begin
          s2_unf_d = 1'b1;
        end else begin
          s2_e_d = s1_exp_q - EW'(s1_lz_q);
          s2_m_d = s1_res_q[MW:0] << s1_lz_q;
        end
      end
    endcase
  end

  // Stage 2 registers: outputs frozen while downstream stalls
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s2_valid_q <= 1'b0;
      s2_e_q     <= '0;
      s2_m_q     <= '0;
      s2_zero_q  <= 1'b0;
      s2_ovf_q   <= 1'b0;
      s2_unf_q   <= 1'b0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_e_q    <= s2_e_d;
        s2_m_q    <= s2_m_d;
        s2_zero_q <= s2_zero_d;
        s2_ovf_q  <= s2_ovf_d;
        s2_unf_q  <= s2_unf_d;
      end
    end
  end

  assign valid_out     = s2_valid_q;
  assign normal_e_out  = s2_e_q;
  assign normal_m_out  = s2_m_q;
  assign zero_out      = s2_zero_q;
  assign overflow_out  = s2_ovf_q;
  assign underflow_out = s2_unf_q;

`ifdef NORM_STATS_EN
  logic [CNT_WIDTH-1:0] ovf_cnt_q;
  logic [CNT_WIDTH-1:0] unf_cnt_q;
  logic                 xfer_out;

  assign xfer_out = s2_valid_q && ready_out;

  // Saturating completion counters; clear wins over a same-cycle increment
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ovf_cnt_q <= '0;
      unf_cnt_q <= '0;
    end else if (clr_stats_in) begin
      ovf_cnt_q <= '0;
      unf_cnt_q <= '0;
    end else begin
      if (xfer_out && s2_ovf_q && (ovf_cnt_q != '1)) ovf_cnt_q <= ovf_cnt_q + 1'b1;
      if (xfer_out && s2_unf_q && (unf_cnt_q != '1)) unf_cnt_q <= unf_cnt_q + 1'b1;
    end
  end

  assign ovf_count_out = ovf_cnt_q;
  assign unf_count_out = unf_cnt_q;
`else
  logic [CNT_WIDTH-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_normalizer_pipe.sv
// Scoreboard bench for normalizer_pipe (EXP_WIDTH=8, MANTISSA_WIDTH=23).
module tb_normalizer_pipe;

`ifdef NORM_STATS_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 16;
`endif

  logic        clk_in = 1'b0;
  logic        rst_n_in, valid_in, ready_in, valid_out, ready_out;
  logic        zero_out, overflow_out, underflow_out;
  logic [7:0]  expoent_in, normal_e_out;
  logic [24:0] result_in;
  logic [23:0] normal_m_out;
`ifdef NORM_STATS_EN
  logic             clr_stats_in;
  logic [CNT_W-1:0] ovf_count_out, unf_count_out;
`endif

  always #5 clk_in = ~clk_in;

  normalizer_pipe #(.EXP_WIDTH(8), .MANTISSA_WIDTH(23), .CNT_WIDTH(CNT_W)) dut (
`ifdef NORM_STATS_EN
    .clr_stats_in (clr_stats_in),
    .ovf_count_out(ovf_count_out),
    .unf_count_out(unf_count_out),
`endif
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .valid_in     (valid_in),
    .ready_in     (ready_in),
    .expoent_in   (expoent_in),
    .result_in    (result_in),
    .valid_out    (valid_out),
    .ready_out    (ready_out),
    .normal_e_out (normal_e_out),
    .normal_m_out (normal_m_out),
    .zero_out     (zero_out),
    .overflow_out (overflow_out),
    .underflow_out(underflow_out)
  );

  typedef struct packed {
    logic [7:0]  e;
    logic [23:0] m;
    logic        z;
    logic        o;
    logic        u;
  } res_t;

  res_t        sb_q[$];
  logic [7:0]  op_e_q[$];
  logic [24:0] op_r_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: normalise by arithmetic on the numeric value of the sum
  function automatic res_t model(input logic [7:0] e, input logic [24:0] r);
    res_t   x;
    longint ei = longint'(e);
    longint rv = longint'(r);
    int     s  = 0;
    x = '0;
    if (rv == 0) begin
      x.z = 1'b1;
    end else if (rv >= (longint'(1) << 24)) begin
      if (ei + 1 >= 255) begin
        x.o = 1'b1;
        x.e = 8'hFF;
      end else begin
        x.e = 8'(ei + 1);
        x.m = 24'(rv / 2);
      end
    end else begin
      while ((rv << s) < (longint'(1) << 23)) s++;
      if (ei <= longint'(s)) begin
        x.u = 1'b1;
      end else begin
        x.e = 8'(ei - longint'(s));
        x.m = 24'(rv << s);
      end
    end
    return x;
  endfunction

  // Monitor: pops expected result on every output transfer; checks stall hold
  res_t act, ex, held;
  bit   hold_pend = 0;
  int   mdl_ovf = 0, mdl_unf = 0;
  always @(negedge clk_in) begin
    #2;
    if (rst_n_in) begin
      act = {normal_e_out, normal_m_out, zero_out, overflow_out, underflow_out};
      if (hold_pend) check("stall_hold", {valid_out, act}, {1'b1, held});
`ifdef NORM_STATS_EN
      check("ovf_count", ovf_count_out, mdl_ovf);
      check("unf_count", unf_count_out, mdl_unf);
`endif
      if (valid_out && ready_out) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got e=%0h m=%0h with empty scoreboard", normal_e_out, normal_m_out);
        end else begin
          ex = sb_q.pop_front();
          check("norm_e", act.e, ex.e);
          check("norm_m", act.m, ex.m);
          check("flags_zou", {act.z, act.o, act.u}, {ex.z, ex.o, ex.u});
          if (ex.o && mdl_ovf < (1 << CNT_W) - 1) mdl_ovf++;
          if (ex.u && mdl_unf < (1 << CNT_W) - 1) mdl_unf++;
        end
      end
`ifdef NORM_STATS_EN
      if (clr_stats_in) begin
        mdl_ovf = 0;
        mdl_unf = 0;
      end
`endif
      hold_pend = valid_out && !ready_out;
      held      = act;
    end else begin
      hold_pend = 0;
      mdl_ovf   = 0;
      mdl_unf   = 0;
    end
  end

  task automatic add_op(input logic [7:0] e, input logic [24:0] r);
    op_e_q.push_back(e);
    op_r_q.push_back(r);
  endtask

  function automatic logic [7:0] gen_exp();
    case ($urandom_range(5))
      0:       return 8'h00;
      1:       return 8'h01;
      2:       return 8'hFE;
      3:       return 8'hFD;
      4:       return 8'($urandom_range(1, 30));
      default: return 8'($urandom);
    endcase
  endfunction

  function automatic logic [24:0] gen_res();
    logic [24:0] r;
    case ($urandom_range(5))
      0:       r = '0;
      1:       r = 25'h1000000 | 25'($urandom);
      2:       r = 25'd1 << $urandom_range(0, 23);
      3:       r = 25'($urandom & 32'h00FFFFFF) >> $urandom_range(0, 23);
      default: r = 25'($urandom);
    endcase
    return r;
  endfunction

  // Drives queued operands; ready_out is random, or held low stall_n cycles at first valid_out
  task automatic run(input int rdy_pct, input int gap_pct, input int stall_n, input bit chk_bp);
    int acc = 0;
    int stall_left = stall_n;
    int guard = 0;
    while (op_e_q.size() > 0 && guard < 5000) begin
      @(negedge clk_in);
      guard++;
      if (stall_left > 0 && valid_out) begin
        ready_out = 1'b0;
        stall_left--;
      end else begin
        ready_out = ($urandom_range(99) < rdy_pct);
      end
      if ($urandom_range(99) < gap_pct) begin
        valid_in = 1'b0;
      end else begin
        valid_in   = 1'b1;
        expoent_in = op_e_q[0];
        result_in  = op_r_q[0];
      end
      #1;
      if (chk_bp && !ready_out && valid_out) begin
        check("bp_ready_in", ready_in, 0);
        check("bp_accepts", acc, 2);
      end
      if (valid_in && ready_in) begin
        sb_q.push_back(model(expoent_in, result_in));
        void'(op_e_q.pop_front());
        void'(op_r_q.pop_front());
        acc++;
      end
    end
    if (op_e_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drive_timeout: got %0d operands pending required 0", op_e_q.size());
      op_e_q.delete();
      op_r_q.delete();
    end
    @(negedge clk_in);
    valid_in  = 1'b0;
    ready_out = 1'b1;
  endtask

  task automatic drain();
    int g = 0;
    while (sb_q.size() > 0 && g < 100) begin
      @(negedge clk_in);
      ready_out = 1'b1;
      g++;
    end
    #3;
    check("drain_empty", sb_q.size(), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid_out"}, valid_out, 0);
    check({tag, "_ready_in"}, ready_in, 1);
    check({tag, "_data"}, {normal_e_out, normal_m_out, zero_out, overflow_out, underflow_out}, 0);
  endtask

  initial begin
    rst_n_in   = 1'b0;
    valid_in   = 1'b0;
    ready_out  = 1'b0;
    expoent_in = '0;
    result_in  = '0;
`ifdef NORM_STATS_EN
    clr_stats_in = 1'b0;
`endif
    repeat (2) @(negedge clk_in);
    #1 check_idle_outputs("in_reset");
    @(negedge clk_in);
    #3 rst_n_in = 1'b1;
    #1 check_idle_outputs("after_reset");

    // Latency: accept, then valid_out two edges later
    @(negedge clk_in);
    ready_out  = 1'b1;
    valid_in   = 1'b1;
    expoent_in = 8'h80;
    result_in  = 25'h1800000;
    #1 check("accept_ready", ready_in, 1);
    if (valid_in && ready_in) sb_q.push_back(model(expoent_in, result_in));
    @(negedge clk_in);
    valid_in = 1'b0;
    #1 check("lat_cycle1_valid", valid_out, 0);
    @(negedge clk_in);
    #1 check("lat_cycle2_valid", valid_out, 1);
    check("carry_e", normal_e_out, 8'h81);
    check("carry_m", normal_m_out, 24'hC00000);
    drain();

    // Boundary vectors
    add_op(8'h80, 25'h0400000);
    add_op(8'h05, 25'h0000001);
    add_op(8'hFE, 25'h1000000);
    add_op(8'hFD, 25'h1000000);
    add_op(8'h7F, 25'h0000000);
    add_op(8'h01, 25'h0800000);
    add_op(8'h00, 25'h0800000);
    add_op(8'hFF, 25'h0800000);
    add_op(8'h18, 25'h0000001);
    run(100, 0, 0, 0);
    drain();

    // Backpressure: 4 back-to-back, ready_out low 3 cycles at first valid_out
    for (int i = 0; i < 4; i++) add_op(gen_exp(), gen_res());
    run(100, 0, 3, 1);
    drain();

`ifdef NORM_STATS_EN
    @(negedge clk_in) clr_stats_in = 1'b1;
    @(negedge clk_in) clr_stats_in = 1'b0;
    #1 check("clr_ovf_zero", ovf_count_out, 0);
    for (int i = 0; i < 3; i++) add_op(8'hFE, 25'h1000000 | 25'(i));
    run(100, 0, 2, 0);
    drain();
    @(negedge clk_in);
    #1 check("ovf_count_three", ovf_count_out, 3);
    for (int i = 0; i < 2; i++) add_op(8'hFF, 25'h1FFFFFF);
    add_op(8'h02, 25'h0000004);
    run(100, 0, 0, 0);
    drain();
    @(negedge clk_in);
    #1 check("ovf_count_sat", ovf_count_out, 3);
    check("unf_count_one", unf_count_out, 1);
    @(negedge clk_in) clr_stats_in = 1'b1;
    @(negedge clk_in) clr_stats_in = 1'b0;
    #1 check("clr_after_sat", ovf_count_out, 0);
`endif

    // Randomised traffic with random stalls and gaps
    for (int i = 0; i < 300; i++) add_op(gen_exp(), gen_res());
    run(70, 25, 0, 0);
    drain();

    // Reset with the pipe full and stalled
    @(negedge clk_in);
    ready_out  = 1'b0;
    valid_in   = 1'b1;
    expoent_in = 8'h40;
    result_in  = 25'h0123456;
    repeat (3) @(negedge clk_in);
    #1 check("pre_reset_valid", valid_out, 1);
    #2;
    rst_n_in = 1'b0;
    valid_in = 1'b0;
    #1 check_idle_outputs("mid_reset");
    sb_q.delete();
    @(negedge clk_in);
    #3 rst_n_in = 1'b1;
    ready_out = 1'b1;

    for (int i = 0; i < 6; i++) add_op(gen_exp(), gen_res());
    run(100, 0, 0, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
